// File: rtl/component_pkg.sv
// Shared helpers for the component_* buffering blocks: log2 sizing and
// pointer-width derivation for wrap-bit FIFO pointers.
package component_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Pointer carries one extra wrap bit above the address bits.
  function automatic int ptr_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/component_fifo_mem.sv
// Two-port register array: synchronous write, asynchronous read, cleared on reset
// so the read port shows zero until the first write lands.
module component_fifo_mem #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/component_fifo.sv
// First-word-fall-through FIFO feeding the component_flop capture stage;
// status outputs are derived from registered pointers only.
module component_fifo
  import component_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   wr_ready,
  output logic                   rd_valid,
  output logic [WIDTH-1:0]       rd_data,
  input  logic                   rd_ready,
  output logic [clog2(DEPTH):0]  count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("component_fifo: DEPTH must be a power of two and at least 2");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("component_fifo: WIDTH must be at least 1");
  end

  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          full_i;
  logic          empty_i;
  logic          push;
  logic          pop;
  logic          ovf_q;

  // Same slot with opposite wrap bits means the writer has lapped the reader.
  assign full_i  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty_i = (wp == rp);

  // A write while full is refused even if a pop frees a slot this cycle.
  assign push = wr_valid && !full_i;
  assign pop  = rd_ready && !empty_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) wp <= wp + PTR_ONE;
      if (pop)  rp <= rp + PTR_ONE;
      ovf_q <= wr_valid && full_i;
    end
  end

  component_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wp[AW-1:0]),
    .wdata (wr_data),
    .raddr (rp[AW-1:0]),
    .rdata (rd_data)
  );

  assign count    = wp - rp;
  assign full     = full_i;
  assign empty    = empty_i;
  assign wr_ready = !full_i;
  assign rd_valid = !empty_i;
  assign overflow = ovf_q;

endmodule

// File: doc/component_fifo.md
# component_fifo

Synchronous first-word-fall-through FIFO that buffers a valid/ready stream and presents it as a valid-qualified data stream to the downstream `component_flop` capture stage. The read side `rd_valid`/`rd_data` connects directly to the flop's `valid_in`/`d_in`. It decouples bursty producers from the single-register capture point and supports back-pressure. It is the generic buffering stage in front of any N-bit flop in the datapath.

## Interface
- `WIDTH`, 1, data width in bits (>= 1)
- `DEPTH`, 4, number of entries; power of two, >= 2
- `clk`  input  1  single clock, all logic on rising edge
- `rst`  input  1  synchronous reset, active-high
- `wr_valid`  input  1  producer presents `wr_data`
- `wr_data`  input  WIDTH  write data
- `wr_ready`  output  1  FIFO can accept a write this cycle (= !full)
- `rd_valid`  output  1  `rd_data` holds the oldest entry (= !empty)
- `rd_data`  output  WIDTH  oldest entry, valid when `rd_valid`
- `rd_ready`  input  1  consumer takes the entry this cycle
- `count`  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH
- `full`  output  1  count == DEPTH
- `empty`  output  1  count == 0
- `overflow`  output  1  one-cycle pulse: write attempted while full

## Operation
- Clock is `clk`; reset is synchronous and active-high on `rst`; no other clock or reset.
- Storage: DEPTH x WIDTH register array; write pointer `wp` and read pointer `rp`, each clog2(DEPTH)+1 bits (extra wrap bit).
- Push: `wr_valid && wr_ready` -> mem[wp[low]] <= wr_data, wp++.
- Pop: `rd_valid && rd_ready` -> rp++.
- Pointers wrap naturally modulo 2*DEPTH; full when low bits equal and wrap bits differ; empty when pointers equal.
- `count` = wp - rp (modulo 2^(clog2(DEPTH)+1)); registered state, no combinational path from inputs.
- `rd_data` = mem[rp[low]] combinationally (FWFT); undefined content is don't-care when `!rd_valid`, but must equal 0 after reset until first write.
- Full boundary: `wr_ready` = !full only; a write while full is NOT accepted even if a pop occurs the same cycle; `overflow` pulses next cycle, data dropped, state unchanged.
- Empty boundary: pop request with `rd_valid` = 0 is ignored, no error flag.
- Simultaneous push and pop when 0 < count < DEPTH: both performed, count unchanged.
- Push into empty with `rd_ready` = 1 the same cycle: only push occurs (no bypass).
- Reset mid-operation: all contents discarded.

## Timing
- Reset values: wp = rp = 0, `count` = 0, `empty` = 1, `full` = 0, `wr_ready` = 1, `rd_valid` = 0, `rd_data` = 0, `overflow` = 0, memory cleared.
- Write-to-read latency: data pushed at edge N appears on `rd_valid`/`rd_data` after edge N (visible in cycle N+1).
- Pop takes effect at the edge where `rd_valid && rd_ready`; next entry presented in the following cycle.
- Throughput: one push and one pop per cycle sustained.
- `wr_ready`, `rd_valid`, `full`, `empty`, `count` depend only on registers.
- `overflow` registered: asserted in cycle after the failed write, for exactly one cycle per failed write cycle.
- Downstream `component_flop` captures `rd_data` on the same edge the FIFO pops when `rd_ready` is tied high.

## Structure
- Shared package `component_pkg`: `clog2` constant function and pointer-width derivation; reused by other components.
- No sub-module required; optionally `component_fifo_mem` (2-port register array, synchronous write, async read) if the memory is to be swapped for a macro later.
- Parameter check: elaboration-time error if DEPTH is not a power of two or < 2.

## Test plan (WIDTH=8, DEPTH=4)
- Reset: assert `rst` 2 cycles with random inputs -> `count`=0, `empty`=1, `wr_ready`=1, `rd_valid`=0, `rd_data`=0x00.
- Fill: push 0x11,0x22,0x33,0x44 with `rd_ready`=0 -> `count` 1,2,3,4; `full`=1, `wr_ready`=0; `rd_data`=0x11 from cycle after first push.
- Overflow: while full push 0x55 with `rd_ready`=1 -> write rejected, `overflow`=1 for one cycle, pop occurs, `count`=3, 0x55 never read.
- Drain and wrap: pop all, then push/pop 10 further words 0xA0..0xA9 -> read order exact, pointers wrap twice, `empty`=1 at end.
- Streaming: continuous push with `rd_ready`=1 at count=2 -> `count` stays 2 for 8 cycles, data order preserved.
- Underflow/reset mid-op: pop on empty -> no change; with count=3 assert `rst` -> next cycle `count`=0, `rd_valid`=0, subsequent push 0x77 read back first.
